regfile_bypass_sb: RTL and testbench

Parametrised multi-read-port register file for the pipelined MIPS datapath. It is the successor to the single-clock 2R/1W register file.
- Writes on the rising edge, with write-through bypass so the decode stage sees same-cycle writeback data.
- Adds a per-register busy scoreboard for load-use/long-latency hazard detection, asynchronous clear, and a debug/display read port.
- Sits between ID (reads, claims) and WB (write, release).

---
 rtl/regfile_bypass_sb_pkg.sv | 24 ++
 rtl/regfile_bypass_sb_if.sv | 32 +++
 rtl/regfile_bypass_sb_read_port.sv | 36 +++
 rtl/regfile_bypass_sb.sv | 99 +++++++++
 tb/tb_regfile_bypass_sb.sv | 218 +++++++++++++++++++++
 5 files changed

// File: rtl/regfile_bypass_sb_pkg.sv
// Shared constants and helpers for the bypassing register file with busy scoreboard.
package regfile_pkg;

    localparam int unsigned DATA_W_DEF = 32;
    localparam int unsigned ADDR_W_DEF = 5;
    localparam int unsigned NUM_RD_DEF = 2;

    // Index of the architectural zero register.
    localparam int unsigned REG_ZERO = 0;

    // Widest busy vector popcount supports (ADDR_W up to 8).
    localparam int unsigned POP_W_MAX = 256;

    // Number of set bits in a (zero-extended) busy vector.
    function automatic int unsigned popcount(input logic [POP_W_MAX-1:0] vec);
        int unsigned n;
        n = 0;
        for (int unsigned i = 0; i < POP_W_MAX; i++) begin
            if (vec[i]) n++;
        end
        return n;
    endfunction

endpackage

// File: rtl/regfile_bypass_sb_if.sv
// Read/write/claim/debug bus of the register file; the pipeline drives it as master.
interface regfile_bypass_sb_if
    import regfile_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned NUM_RD = NUM_RD_DEF
);

    logic [NUM_RD*ADDR_W-1:0] rd_addr;
    logic [NUM_RD*DATA_W-1:0] rd_data;
    logic [NUM_RD-1:0]        rd_busy;
    logic                     we;
    logic [ADDR_W-1:0]        wr_addr;
    logic [DATA_W-1:0]        wr_data;
    logic                     claim_en;
    logic [ADDR_W-1:0]        claim_addr;
    logic [ADDR_W-1:0]        dbg_addr;
    logic [DATA_W-1:0]        dbg_data;
    logic [ADDR_W:0]          busy_count;

    modport master (
        output rd_addr, we, wr_addr, wr_data, claim_en, claim_addr, dbg_addr,
        input  rd_data, rd_busy, dbg_data, busy_count
    );

    modport slave (
        input  rd_addr, we, wr_addr, wr_data, claim_en, claim_addr, dbg_addr,
        output rd_data, rd_busy, dbg_data, busy_count
    );

endinterface

// File: rtl/regfile_bypass_sb_read_port.sv
// One read port: zero-register forcing, writeback bypass and hazard flag.
module regfile_read_port
    import regfile_pkg::*;
#(
    parameter int unsigned DATA_W   = DATA_W_DEF,
    parameter int unsigned ADDR_W   = ADDR_W_DEF,
    parameter int unsigned ZERO_REG = 1
) (
    input  logic [ADDR_W-1:0] rd_addr_i,
    input  logic [DATA_W-1:0] stored_data_i,
    input  logic              stored_busy_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] wr_addr_i,
    input  logic [DATA_W-1:0] wr_data_i,
    output logic [DATA_W-1:0] rd_data_o,
    output logic              rd_busy_o
);

    logic hit;
    logic is_zero;

    // Same-cycle writeback both supplies the data and satisfies the hazard.
    always_comb begin
        hit       = we_i && (wr_addr_i == rd_addr_i);
        is_zero   = (ZERO_REG != 0) && (rd_addr_i == ADDR_W'(REG_ZERO));
        rd_data_o = stored_data_i;
        rd_busy_o = stored_busy_i && !hit;
        if (is_zero) begin
            rd_data_o = '0;
            rd_busy_o = 1'b0;
        end else if (hit) begin
            rd_data_o = wr_data_i;
        end
    end

endmodule

// File: rtl/regfile_bypass_sb.sv
// Multi-read-port register file with write-through bypass, busy scoreboard and debug port.
module regfile_bypass_sb
    import regfile_pkg::*;
#(
    parameter int unsigned DATA_W   = DATA_W_DEF,
    parameter int unsigned ADDR_W   = ADDR_W_DEF,
    parameter int unsigned NUM_RD   = NUM_RD_DEF,
    parameter int unsigned ZERO_REG = 1
) (
    input  logic                clk,
    input  logic                rst,
    regfile_bypass_sb_if.slave  bus
);

    localparam int unsigned DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0]    mem_q [DEPTH];
    logic [DEPTH-1:0]     busy_q;
    logic [DEPTH-1:0]     busy_d;
    logic                 wr_ok;
    logic                 claim_ok;
    logic [POP_W_MAX-1:0] busy_ext;
    logic [DATA_W-1:0]    port_data [NUM_RD];
    logic                 port_busy [NUM_RD];

    // Qualify write and claim; register 0 is immune when hardwired.
    always_comb begin
        wr_ok    = bus.we &&
                   !((ZERO_REG != 0) && (bus.wr_addr == ADDR_W'(REG_ZERO)));
        claim_ok = bus.claim_en &&
                   !((ZERO_REG != 0) && (bus.claim_addr == ADDR_W'(REG_ZERO)));
    end

    // Release on writeback first so a same-cycle claim of that register wins.
    always_comb begin
        busy_d = busy_q;
        if (bus.we) busy_d[bus.wr_addr] = 1'b0;
        if (claim_ok) busy_d[bus.claim_addr] = 1'b1;
    end

    // Register storage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else if (wr_ok) begin
            mem_q[bus.wr_addr] <= bus.wr_data;
        end
    end

    // Busy scoreboard.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) busy_q <= '0;
        else     busy_q <= busy_d;
    end

    for (genvar g = 0; g < NUM_RD; g++) begin : g_rd
        logic [ADDR_W-1:0] addr;
        assign addr = bus.rd_addr[g*ADDR_W +: ADDR_W];

        regfile_read_port #(
            .DATA_W   (DATA_W),
            .ADDR_W   (ADDR_W),
            .ZERO_REG (ZERO_REG)
        ) u_port (
            .rd_addr_i     (addr),
            .stored_data_i (mem_q[addr]),
            .stored_busy_i (busy_q[addr]),
            .we_i          (bus.we),
            .wr_addr_i     (bus.wr_addr),
            .wr_data_i     (bus.wr_data),
            .rd_data_o     (port_data[g]),
            .rd_busy_o     (port_busy[g])
        );
    end

    // Pack per-port results onto the flat bus vectors.
    always_comb begin
        bus.rd_data = '0;
        bus.rd_busy = '0;
        for (int unsigned i = 0; i < NUM_RD; i++) begin
            bus.rd_data[i*DATA_W +: DATA_W] = port_data[i];
            bus.rd_busy[i]                  = port_busy[i];
        end
    end

    // Debug read shows raw stored contents, never the bypass.
    always_comb begin
        bus.dbg_data = mem_q[bus.dbg_addr];
        if ((ZERO_REG != 0) && (bus.dbg_addr == ADDR_W'(REG_ZERO))) bus.dbg_data = '0;
    end

    // Busy count is derived from registered state only.
    always_comb begin
        busy_ext              = '0;
        busy_ext[DEPTH-1:0]   = busy_q;
        bus.busy_count        = (ADDR_W+1)'(popcount(busy_ext));
    end

endmodule

// File: tb/tb_regfile_bypass_sb.sv
// Scoreboard bench: two instances (3 ports / zero reg hardwired, 2 ports / ordinary r0)
// share one stimulus stream and are checked against an array-based reference model.
module tb_regfile_bypass_sb;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    regfile_bypass_sb_if #(.DATA_W(32), .ADDR_W(5), .NUM_RD(3)) ifa ();
    regfile_bypass_sb_if #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2)) ifb ();

    regfile_bypass_sb #(.DATA_W(32), .ADDR_W(5), .NUM_RD(3), .ZERO_REG(1)) dut_a (
        .clk (clk), .rst (rst), .bus (ifa.slave)
    );
    regfile_bypass_sb #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2), .ZERO_REG(0)) dut_b (
        .clk (clk), .rst (rst), .bus (ifb.slave)
    );

    typedef struct packed {
        logic [2:0][31:0] a_rd;
        logic [2:0]       a_bsy;
        logic [31:0]      a_dbg;
        logic [5:0]       a_cnt;
        logic [1:0][31:0] b_rd;
        logic [1:0]       b_bsy;
        logic [31:0]      b_dbg;
        logic [5:0]       b_cnt;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // Reference model: index 0 = hardwired-zero instance, 1 = ordinary r0.
    logic [31:0] mem_m  [2][32];
    logic        busy_m [2][32];

    function automatic logic [31:0] m_read(int k, logic [4:0] ra, logic w, logic [4:0] wa,
                                           logic [31:0] wd);
        if (k == 0 && ra == 5'd0) return 32'd0;
        if (w && wa == ra) return wd;
        return mem_m[k][ra];
    endfunction

    function automatic logic m_busy(int k, logic [4:0] ra, logic w, logic [4:0] wa);
        if (k == 0 && ra == 5'd0) return 1'b0;
        return busy_m[k][ra] && !(w && wa == ra);
    endfunction

    function automatic logic [5:0] m_cnt(int k);
        int n = 0;
        for (int i = 0; i < 32; i++) if (busy_m[k][i]) n++;
        return 6'(n);
    endfunction

    task automatic m_clear();
        for (int k = 0; k < 2; k++)
            for (int i = 0; i < 32; i++) begin
                mem_m[k][i]  = 32'd0;
                busy_m[k][i] = 1'b0;
            end
    endtask

    task automatic step(input logic r, input logic w, input logic [4:0] wa,
                        input logic [31:0] wd, input logic c, input logic [4:0] ca,
                        input logic [4:0] ra0, input logic [4:0] ra1, input logic [4:0] ra2,
                        input logic [4:0] da);
        exp_t e;
        logic [4:0] ra [3];
        @(negedge clk);
        rst = r;
        ra[0] = ra0; ra[1] = ra1; ra[2] = ra2;
        ifa.rd_addr = {ra2, ra1, ra0};
        ifb.rd_addr = {ra1, ra0};
        ifa.we = w;  ifb.we = w;
        ifa.wr_addr = wa; ifb.wr_addr = wa;
        ifa.wr_data = wd; ifb.wr_data = wd;
        ifa.claim_en = c; ifb.claim_en = c;
        ifa.claim_addr = ca; ifb.claim_addr = ca;
        ifa.dbg_addr = da; ifb.dbg_addr = da;
        if (r) m_clear();
        for (int i = 0; i < 3; i++) begin
            e.a_rd[i]  = m_read(0, ra[i], w, wa, wd);
            e.a_bsy[i] = m_busy(0, ra[i], w, wa);
        end
        for (int i = 0; i < 2; i++) begin
            e.b_rd[i]  = m_read(1, ra[i], w, wa, wd);
            e.b_bsy[i] = m_busy(1, ra[i], w, wa);
        end
        e.a_dbg = (da == 5'd0) ? 32'd0 : mem_m[0][da];
        e.b_dbg = mem_m[1][da];
        e.a_cnt = m_cnt(0);
        e.b_cnt = m_cnt(1);
        exp_q.push_back(e);
        if (!r) begin
            for (int k = 0; k < 2; k++) begin
                if (w && !(k == 0 && wa == 5'd0)) mem_m[k][wa] = wd;
                if (w) busy_m[k][wa] = 1'b0;
                if (c && !(k == 0 && ca == 5'd0)) busy_m[k][ca] = 1'b1;
            end
        end
    endtask

    task automatic idle_read(input logic [4:0] ra0, input logic [4:0] ra1,
                             input logic [4:0] ra2, input logic [4:0] da);
        step(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, ra0, ra1, ra2, da);
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s @%0t: got %h, required %h", nm, $time, act, req);
        end
    endtask

    // Monitor: outputs are combinational, so every cycle presents a result to check.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                for (int i = 0; i < 3; i++) begin
                    chk($sformatf("a_rd_data%0d", i), ifa.rd_data[i*32 +: 32], e.a_rd[i]);
                    chk($sformatf("a_rd_busy%0d", i), 32'(ifa.rd_busy[i]), 32'(e.a_bsy[i]));
                end
                for (int i = 0; i < 2; i++) begin
                    chk($sformatf("b_rd_data%0d", i), ifb.rd_data[i*32 +: 32], e.b_rd[i]);
                    chk($sformatf("b_rd_busy%0d", i), 32'(ifb.rd_busy[i]), 32'(e.b_bsy[i]));
                end
                chk("a_dbg_data", ifa.dbg_data, e.a_dbg);
                chk("b_dbg_data", ifb.dbg_data, e.b_dbg);
                chk("a_busy_count", 32'(ifa.busy_count), 32'(e.a_cnt));
                chk("b_busy_count", 32'(ifb.busy_count), 32'(e.b_cnt));
            end
        end
    end

    function automatic logic [4:0] rand_addr();
        if ($urandom_range(0, 3) == 0) return 5'($urandom_range(0, 31));
        return 5'($urandom_range(0, 5));
    endfunction

    initial begin
        m_clear();
        ifa.rd_addr = '0; ifb.rd_addr = '0;
        ifa.we = 1'b0; ifb.we = 1'b0;
        ifa.wr_addr = '0; ifb.wr_addr = '0;
        ifa.wr_data = '0; ifb.wr_data = '0;
        ifa.claim_en = 1'b0; ifb.claim_en = 1'b0;
        ifa.claim_addr = '0; ifb.claim_addr = '0;
        ifa.dbg_addr = '0; ifb.dbg_addr = '0;

        // Reset state, then reset mid-operation wipes r5.
        step(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd5, 5'd0, 5'd1, 5'd5);
        step(1'b0, 1'b1, 5'd5, 32'hDEADBEEF, 1'b1, 5'd5, 5'd5, 5'd1, 5'd2, 5'd5);
        idle_read(5'd5, 5'd5, 5'd5, 5'd5);
        step(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd5, 5'd5, 5'd5, 5'd5);
        idle_read(5'd5, 5'd5, 5'd5, 5'd5);

        // Bypass and raw debug view around the write edge.
        step(1'b0, 1'b1, 5'd7, 32'h12345678, 1'b0, 5'd0, 5'd7, 5'd7, 5'd7, 5'd7);
        idle_read(5'd7, 5'd6, 5'd7, 5'd7);

        // Register 0 write and claim.
        step(1'b0, 1'b1, 5'd0, 32'hFFFFFFFF, 1'b1, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0);
        idle_read(5'd0, 5'd0, 5'd0, 5'd0);
        step(1'b0, 1'b1, 5'd0, 32'd1, 1'b0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0);

        // Claim r3, then satisfy it by writeback.
        step(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd3, 5'd3, 5'd3, 5'd3, 5'd3);
        idle_read(5'd3, 5'd3, 5'd2, 5'd3);
        step(1'b0, 1'b1, 5'd3, 32'h000000A5, 1'b0, 5'd0, 5'd3, 5'd3, 5'd3, 5'd3);
        idle_read(5'd3, 5'd3, 5'd3, 5'd3);

        // Simultaneous claim and write of r9; double claim of r4, single release.
        step(1'b0, 1'b1, 5'd9, 32'h99999999, 1'b1, 5'd9, 5'd9, 5'd9, 5'd9, 5'd9);
        step(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd4, 5'd9, 5'd4, 5'd9, 5'd9);
        step(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd4, 5'd4, 5'd9, 5'd4, 5'd4);
        step(1'b0, 1'b1, 5'd4, 32'h44, 1'b0, 5'd0, 5'd4, 5'd4, 5'd9, 5'd4);
        step(1'b0, 1'b1, 5'd9, 32'h9, 1'b0, 5'd0, 5'd4, 5'd9, 5'd4, 5'd9);

        // Three ports, r12 written while read alongside other registers.
        step(1'b0, 1'b1, 5'd12, 32'hC0FFEE12, 1'b0, 5'd0, 5'd12, 5'd7, 5'd12, 5'd12);
        step(1'b0, 1'b1, 5'd12, 32'h0BADF00D, 1'b1, 5'd7, 5'd3, 5'd12, 5'd12, 5'd12);
        idle_read(5'd12, 5'd7, 5'd3, 5'd12);

        // Claim every register (full scoreboard), then release them all.
        for (int i = 0; i < 32; i++)
            step(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'(i), 5'(i), 5'd31, 5'd0, 5'(i));
        idle_read(5'd31, 5'd0, 5'd1, 5'd31);
        for (int i = 0; i < 32; i++)
            step(1'b0, 1'b1, 5'(i), $urandom, 1'b0, 5'd0, 5'(i), 5'(i), 5'd0, 5'(i));
        idle_read(5'd31, 5'd0, 5'd1, 5'd31);

        // Randomized traffic with occasional asynchronous reset.
        for (int n = 0; n < 600; n++) begin
            step(1'b0 || ($urandom_range(0, 79) == 0),
                 1'($urandom_range(0, 1)), rand_addr(), $urandom,
                 1'($urandom_range(0, 1)), rand_addr(),
                 rand_addr(), rand_addr(), rand_addr(), rand_addr());
        end
        idle_read(5'd1, 5'd2, 5'd3, 5'd4);

        @(negedge clk);
        #4;
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL scoreboard_drain: got %0d pending, required 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
